// File: rtl/q2_lcd_keypad_io.sv
// q2 memory-mapped I/O at address 0xFFF.
// Writes are queued as HD44780 transfers (character, set-address, clear) and
// played out by a sequencer that also runs the power-on init. Reads return the
// debounced, active-low keypad state.
module q2_lcd_keypad_io #(
    parameter int FIFO_DEPTH = 8,
    parameter int POR_WAIT   = 1500,
    parameter int SHORT_WAIT = 4,
    parameter int LONG_WAIT  = 165,
    parameter int E_CYCLES   = 1,
    parameter int DEBOUNCE   = 320
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_abus,
    input  logic [11:0] i_dbus_in,
    output logic [11:0] o_dbus_out,
    output logic        o_dbus_oe,
    input  logic        i_wrm,
    input  logic        i_rdm,
    input  logic [11:0] i_key_n,
    output logic        o_lcd_rs,
    output logic        o_lcd_e,
    output logic [7:0]  o_lcd_d,
    output logic        o_lcd_ready,
    output logic        o_fifo_full,
    output logic [2:0]  o_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [15:0] POR_LIM   = 16'(POR_WAIT - 1);
    localparam logic [15:0] SHORT_LIM = 16'(SHORT_WAIT - 1);
    localparam logic [15:0] LONG_LIM  = 16'(LONG_WAIT - 1);
    localparam logic [15:0] E_LIM     = 16'(E_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LIM = DW'(DEBOUNCE - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [12:0] IO_ADDR   = 13'h0FFF;

    // Sequencer states; INIT loads the next fixed command, IDLE pops the FIFO.
    typedef enum logic [2:0] {
        S_POR   = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_SETUP = 3'd3,
        S_PULSE = 3'd4,
        S_HOLD  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    // Bus decode and write-strobe edge detect
    logic          r_wrm_q;
    logic          w_sel;
    logic          w_wr_edge;
    logic          w_cmd_valid;
    logic [8:0]    w_cmd;
    logic          w_unused_bits;

    // FIFO
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_full;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    // Sequencer
    state_t        r_state;
    state_t        w_next_state;
    logic [15:0]   r_cnt;
    logic [15:0]   w_next_cnt;
    logic [2:0]    r_step;
    logic [2:0]    w_next_step;
    logic          r_in_init;
    logic          w_next_in_init;
    logic          r_rs;
    logic          w_next_rs;
    logic [7:0]    r_d;
    logic [7:0]    w_next_d;
    logic [7:0]    w_init_cmd;
    logic [15:0]   w_wait_lim;

    // Keypad
    logic [11:0]   r_sync1;
    logic [11:0]   r_sync2;
    logic [DW-1:0] r_div;
    logic [11:0]   r_samp;
    logic [11:0]   r_key;
    logic [11:0]   w_agree;

    assign w_sel         = ({1'b0, i_abus} == IO_ADDR);
    assign w_wr_edge     = i_wrm & ~r_wrm_q & w_sel;
    assign w_unused_bits = ^i_dbus_in[11:9];

    // Remember the previous write strobe so each CPU write pushes only once
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrm_q <= 1'b0;
        end else begin
            r_wrm_q <= i_wrm;
        end
    end

    // Translate CPU write data into an LCD transfer {rs, d}
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd       = 9'h000;
        if (!i_dbus_in[8]) begin
            w_cmd_valid = 1'b1;
            if ((i_dbus_in[7:0] < 8'h20) || (i_dbus_in[7:0] > 8'h7E)) begin
                w_cmd = {1'b1, 8'h3F};
            end else begin
                w_cmd = {1'b1, i_dbus_in[7:0]};
            end
        end else if (i_dbus_in[7]) begin
            w_cmd_valid = 1'b1;
            w_cmd       = {1'b0, 1'b1, i_dbus_in[6:0]};
        end else if (i_dbus_in[0]) begin
            w_cmd_valid = 1'b1;
            w_cmd       = {1'b0, 8'h01};
        end
    end

    // A push while full is dropped even if a pop happens in the same cycle
    assign w_empty = (r_count == '0);
    assign w_push  = w_wr_edge & w_cmd_valid & ~r_full;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;

    // Next FIFO occupancy
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (AW + 1)'(1);
            2'b01:   w_count_next = r_count - (AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_cmd;
        end
    end

    // Fixed HD44780 8-bit init: function set x3, display on, entry mode, clear
    always_comb begin
        case (r_step)
            3'd0, 3'd1, 3'd2: w_init_cmd = 8'h38;
            3'd3:             w_init_cmd = 8'h0C;
            3'd4:             w_init_cmd = 8'h06;
            default:          w_init_cmd = 8'h01;
        endcase
    end

    // Clear needs the long settle time, everything else the short one
    assign w_wait_lim = ({r_rs, r_d} == 9'h001) ? LONG_LIM : SHORT_LIM;

    // Sequencer next-state logic
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_step    = r_step;
        w_next_in_init = r_in_init;
        w_next_rs      = r_rs;
        w_next_d       = r_d;
        case (r_state)
            S_POR: begin
                if (r_cnt == POR_LIM) begin
                    w_next_state   = S_INIT;
                    w_next_cnt     = '0;
                    w_next_step    = '0;
                    w_next_in_init = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + 16'd1;
                end
            end
            S_INIT: begin
                w_next_rs    = 1'b0;
                w_next_d     = w_init_cmd;
                w_next_state = S_SETUP;
            end
            S_IDLE: begin
                if (!w_empty) begin
                    {w_next_rs, w_next_d} = r_mem[r_rptr];
                    w_next_state          = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_PULSE;
                w_next_cnt   = '0;
            end
            S_PULSE: begin
                if (r_cnt == E_LIM) begin
                    w_next_state = S_HOLD;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 16'd1;
                end
            end
            S_HOLD: begin
                w_next_state = S_WAIT;
                w_next_cnt   = '0;
            end
            S_WAIT: begin
                if (r_cnt == w_wait_lim) begin
                    w_next_cnt = '0;
                    if (r_in_init) begin
                        if (r_step == 3'd5) begin
                            w_next_state   = S_IDLE;
                            w_next_in_init = 1'b0;
                        end else begin
                            w_next_step  = r_step + 3'd1;
                            w_next_state = S_INIT;
                        end
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_cnt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_next_state = S_POR;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Sequencer registers; reset aborts any transfer and restarts the POR wait
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_POR;
            r_cnt     <= '0;
            r_step    <= '0;
            r_in_init <= 1'b0;
            r_rs      <= 1'b0;
            r_d       <= 8'h00;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_step    <= w_next_step;
            r_in_init <= w_next_in_init;
            r_rs      <= w_next_rs;
            r_d       <= w_next_d;
        end
    end

    // Keypad bits change only when two consecutive samples agree
    assign w_agree = ~(r_samp ^ r_sync2);

    // Synchronise, sample every DEBOUNCE cycles, and filter the keypad
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 12'hFFF;
            r_sync2 <= 12'hFFF;
            r_div   <= '0;
            r_samp  <= 12'hFFF;
            r_key   <= 12'hFFF;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (r_div == DIV_LIM) begin
                r_div  <= '0;
                r_samp <= r_sync2;
                r_key  <= (r_key & ~w_agree) | (r_sync2 & w_agree);
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign o_dbus_oe   = i_rdm & w_sel;
    assign o_dbus_out  = r_key;
    assign o_lcd_e     = (r_state == S_PULSE);
    assign o_lcd_rs    = r_rs;
    assign o_lcd_d     = r_d;
    assign o_lcd_ready = (r_state == S_IDLE) & w_empty;
    assign o_fifo_full = r_full;
    assign o_state     = r_state;

endmodule

// File: tb/tb_q2_lcd_keypad_io.sv
// Bench for q2_lcd_keypad_io: directed write vectors plus init, FIFO,
// keypad and reset-abort sequences.
module tb_q2_lcd_keypad_io;

  localparam int FIFO_DEPTH = 8;
  localparam int POR_WAIT   = 1500;
  localparam int SHORT_WAIT = 4;
  localparam int LONG_WAIT  = 165;
  localparam int E_CYCLES   = 1;
  localparam int DEBOUNCE   = 320;
  localparam int NV         = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] i_abus = 12'h000;
  logic [11:0] i_dbus_in = 12'h000;
  logic        i_wrm = 1'b0;
  logic        i_rdm = 1'b0;
  logic [11:0] i_key_n = 12'hFFF;
  logic [11:0] o_dbus_out;
  logic        o_dbus_oe;
  logic        o_lcd_rs;
  logic        o_lcd_e;
  logic [7:0]  o_lcd_d;
  logic        o_lcd_ready;
  logic        o_fifo_full;
  logic [2:0]  o_state;

  q2_lcd_keypad_io #(
    .FIFO_DEPTH(FIFO_DEPTH), .POR_WAIT(POR_WAIT), .SHORT_WAIT(SHORT_WAIT),
    .LONG_WAIT(LONG_WAIT), .E_CYCLES(E_CYCLES), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_abus(i_abus), .i_dbus_in(i_dbus_in),
    .o_dbus_out(o_dbus_out), .o_dbus_oe(o_dbus_oe), .i_wrm(i_wrm),
    .i_rdm(i_rdm), .i_key_n(i_key_n), .o_lcd_rs(o_lcd_rs), .o_lcd_e(o_lcd_e),
    .o_lcd_d(o_lcd_d), .o_lcd_ready(o_lcd_ready), .o_fifo_full(o_fifo_full),
    .o_state(o_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: capture {rs,d} and cycle at every rising lcd_e
  logic [8:0] got_q[$];
  int         got_t_q[$];
  logic [8:0] exp_q[$];
  logic       prev_e = 1'b0;
  always @(negedge clk) begin
    if (o_lcd_e && !prev_e) begin
      got_q.push_back({o_lcd_rs, o_lcd_d});
      got_t_q.push_back(cyc);
    end
    prev_e = o_lcd_e;
  end

  int n_vec = 0;
  int n_err = 0;
  int t_rel = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    i_abus = a; i_dbus_in = d; i_wrm = 1'b1;
    repeat (2) @(negedge clk);
    i_wrm = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_rst_e"}, 32'(o_lcd_e), 0);
    check({tag, "_rst_rs"}, 32'(o_lcd_rs), 0);
    check({tag, "_rst_d"}, 32'(o_lcd_d), 0);
    check({tag, "_rst_ready"}, 32'(o_lcd_ready), 0);
    check({tag, "_rst_full"}, 32'(o_fifo_full), 0);
    check({tag, "_rst_dbus"}, 32'(o_dbus_out), 32'hFFF);
    rst = 1'b0;
    t_rel = cyc;
    got_q.delete(); got_t_q.delete();
  endtask

  task automatic wait_ready(input string name, input int bound, output int t);
    t = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (o_lcd_ready) begin
        t = cyc;
        break;
      end
    end
    check({name, "_ready_timeout"}, 32'(t >= 0), 1);
  endtask

  // scoreboard drain: count then in-order contents
  task automatic compare_all(input string tag);
    logic [8:0] g, e;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rsd"}, 32'(g), 32'(e));
    end
    got_q.delete(); got_t_q.delete(); exp_q.delete();
  endtask

  task automatic push_init_exp();
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C); exp_q.push_back(9'h006); exp_q.push_back(9'h001);
  endtask

  // init sequence with timing checks on the POR wait and the clear settle
  task automatic run_init(input string tag);
    int t;
    push_init_exp();
    wait_ready(tag, 3000, t);
    if (got_t_q.size() == 6) begin
      check_range({tag, "_por_wait"}, got_t_q[0] - t_rel, POR_WAIT, POR_WAIT + 4);
      for (int i = 1; i < 6; i++)
        check_range({tag, "_short_gap"}, got_t_q[i] - got_t_q[i-1], SHORT_WAIT + E_CYCLES + 1, SHORT_WAIT + 8);
      check_range({tag, "_clear_gap"}, t - got_t_q[5], LONG_WAIT, LONG_WAIT + 4);
    end
    compare_all(tag);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    bit          pulse;
    logic [8:0]  exp;
  } vec_t;
  vec_t vecs[NV];

  initial begin
    int t, t0;
    bit seen;

    vecs[0] = '{12'hFFF, 12'h041, 1'b1, 9'h141};
    vecs[1] = '{12'hFFF, 12'h007, 1'b1, 9'h13F};
    vecs[2] = '{12'hFFF, 12'h1C0, 1'b1, 9'h0C0};
    vecs[3] = '{12'hFFF, 12'h101, 1'b1, 9'h001};
    vecs[4] = '{12'hFFF, 12'h102, 1'b0, 9'h000};
    vecs[5] = '{12'hFFE, 12'h041, 1'b0, 9'h000};
    vecs[6] = '{12'hFFF, 12'h07F, 1'b1, 9'h13F};
    vecs[7] = '{12'hFFF, 12'h020, 1'b1, 9'h120};
    vecs[8] = '{12'hFFF, 12'hE7E, 1'b1, 9'h17E};
    vecs[9] = '{12'hFFF, 12'h1A5, 1'b1, 9'h0A5};

    // reset and power-on init
    do_reset("por");
    check("rst_state", 32'(o_state), 0);
    run_init("init");

    // table-driven write vectors
    for (int i = 0; i < NV; i++) begin
      cpu_write(vecs[i].addr, vecs[i].data);
      if (vecs[i].pulse) begin
        exp_q.push_back(vecs[i].exp);
        wait_ready($sformatf("vec%0d", i), 600, t);
      end else begin
        repeat (30) @(negedge clk);
        check($sformatf("vec%0d_ready", i), 32'(o_lcd_ready), 1);
      end
      compare_all($sformatf("vec%0d", i));
    end

    // clear followed immediately by a character: long settle before the next pulse
    cpu_write(12'hFFF, 12'h101);
    cpu_write(12'hFFF, 12'h041);
    exp_q.push_back(9'h001); exp_q.push_back(9'h141);
    wait_ready("clr_chr", 800, t);
    if (got_t_q.size() == 2)
      check_range("clr_chr_gap", got_t_q[1] - got_t_q[0], LONG_WAIT, LONG_WAIT + 8);
    compare_all("clr_chr");

    // ten writes during POR: full after eight, eight transfers after init
    do_reset("fifo");
    for (int i = 0; i < 10; i++) begin
      cpu_write(12'hFFF, 12'h041 + 12'(i));
      if (i == 6) check("full_after7", 32'(o_fifo_full), 0);
      if (i == 7) check("full_after8", 32'(o_fifo_full), 1);
      if (i == 9) check("full_after10", 32'(o_fifo_full), 1);
    end
    push_init_exp();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    wait_ready("fifo", 3000, t);
    check("fifo_full_drained", 32'(o_fifo_full), 0);
    compare_all("fifo");

    // keypad read path and debounce
    @(negedge clk);
    i_rdm = 1'b1; i_abus = 12'hFFE;
    #1 check("oe_other_addr", 32'(o_dbus_oe), 0);
    i_abus = 12'hFFF;
    #1 check("oe_sel", 32'(o_dbus_oe), 1);
    check("keys_idle", 32'(o_dbus_out), 32'hFFF);
    i_rdm = 1'b0;
    #1 check("oe_no_rdm", 32'(o_dbus_oe), 0);
    i_rdm = 1'b1;
    @(negedge clk);
    i_key_n[9] = 1'b0;
    repeat (2 * DEBOUNCE + 2) @(posedge clk);
    #1 check("key9_pressed", 32'(o_dbus_out), 32'hDFF);
    seen = 1'b0;
    @(negedge clk);
    i_key_n[3] = 1'b0;
    for (int k = 0; k < DEBOUNCE - 1; k++) begin
      @(negedge clk);
      seen = seen | ~o_dbus_out[3];
    end
    i_key_n[3] = 1'b1;
    for (int k = 0; k < 3 * DEBOUNCE; k++) begin
      @(negedge clk);
      seen = seen | ~o_dbus_out[3];
    end
    check("key3_glitch", 32'(seen), 0);
    check("key9_held", 32'(o_dbus_out), 32'hDFF);
    i_key_n = 12'hFFF;
    i_rdm = 1'b0;

    // reset during the PULSE of a data transfer
    cpu_write(12'hFFF, 12'h101);
    cpu_write(12'hFFF, 12'h041);
    cpu_write(12'hFFF, 12'h042);
    t0 = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (o_lcd_e && o_lcd_rs) begin
        t0 = cyc;
        break;
      end
    end
    check("abort_pulse_seen", 32'(t0 >= 0), 1);
    check("abort_pulse_d", 32'(o_lcd_d), 32'h41);
    rst = 1'b1;
    @(negedge clk);
    check("abort_e", 32'(o_lcd_e), 0);
    check("abort_full", 32'(o_fifo_full), 0);
    check("abort_ready", 32'(o_lcd_ready), 0);
    check("abort_state", 32'(o_state), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t_rel = cyc;
    got_q.delete(); got_t_q.delete();
    run_init("reinit");
    repeat (20) @(negedge clk);
    check("reinit_fifo_empty", 32'(got_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
